// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests instructions from memory,
// holds each one until decode takes it, and follows redirects. It stops
// fetching once a HALT (opcode 5'b00000) has been accepted by decode.
//
// state | meaning
// RST   | leaving reset, next edge starts fetching
// FETCH | imem_req high, waiting for imem_ack
// HOLD  | instruction held for decode, dec_valid high
// HALT  | HALT consumed, nothing more is fetched until reset
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic [PC_W-1:0]    dec_pc_inc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [15:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_RST = {RESET_PC[PC_W-1:1], 1'b0};
    localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    // Address actually presented to memory; lags pc while a redirected
    // request is still waiting for its ack so the bus stays stable.
    logic [PC_W-1:0]    req_addr_q, req_addr_d;
    logic               squash_q, squash_d;
    logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
    logic [PC_W-1:0]    dec_pc_q, dec_pc_d;
    logic [PC_W-1:0]    dec_pc_inc_q, dec_pc_inc_d;
    logic [15:0]        fetch_cnt_q, fetch_cnt_d;

    logic [PC_W-1:0]    redir_aligned;
    logic               is_halt_op;

    assign redir_aligned = {redirect_pc[PC_W-1:1], 1'b0};
    assign is_halt_op    = (dec_instr_q[INSTR_W-1 -: 5] == 5'b00000);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            pc_q         <= PC_RST;
            req_addr_q   <= PC_RST;
            squash_q     <= 1'b0;
            dec_instr_q  <= '0;
            dec_pc_q     <= '0;
            dec_pc_inc_q <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            squash_q     <= squash_d;
            dec_instr_q  <= dec_instr_d;
            dec_pc_q     <= dec_pc_d;
            dec_pc_inc_q <= dec_pc_inc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        squash_d     = squash_q;
        dec_instr_d  = dec_instr_q;
        dec_pc_d     = dec_pc_q;
        dec_pc_inc_d = dec_pc_inc_q;
        fetch_cnt_d  = fetch_cnt_q;

        unique case (state_q)
            ST_RST: begin
                state_d    = ST_FETCH;
                req_addr_d = pc_q;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        // Returned word belongs to the abandoned path.
                        pc_d       = redir_aligned;
                        req_addr_d = redir_aligned;
                        squash_d   = 1'b0;
                    end else if (squash_q) begin
                        // Late ack for the pre-redirect address: drop it and
                        // only now move the bus to the new pc.
                        req_addr_d = pc_q;
                        squash_d   = 1'b0;
                    end else begin
                        dec_instr_d  = imem_rdata;
                        dec_pc_d     = pc_q;
                        dec_pc_inc_d = pc_q + PC_TWO;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request is never withdrawn; keep req_addr until ack.
                    pc_d     = redir_aligned;
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redir_aligned;
                    req_addr_d = redir_aligned;
                    state_d    = ST_FETCH;
                end else if (dec_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                    if (is_halt_op) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d       = pc_q + PC_TWO;
                        req_addr_d = pc_q + PC_TWO;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign dec_valid  = (state_q == ST_HOLD);
    assign halted     = (state_q == ST_HALT);
    assign imem_addr  = req_addr_q;
    assign dec_instr  = dec_instr_q;
    assign dec_pc     = dec_pc_q;
    assign dec_pc_inc = dec_pc_inc_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a zero-wait-capable memory model whose
// ack is gated by imem_req, so requests vanish when the DUT is reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [15:0] dec_pc_inc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_cnt;

    logic        ack_en;
    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_inc     (dec_pc_inc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        ack_en         = 1'b0;
        // Default contents: opcode 00001, low bits = word index, never HALT.
        for (int i = 0; i < 32768; i++) mem[i] = {5'b00001, i[10:0]};
        mem[0] = 16'h4000;
        mem[1] = 16'h0000;
        #12;
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_halt",  {31'd0, halted},    32'd0);
        chk("rst_instr", {16'd0, dec_instr}, 32'd0);
        chk("rst_cnt",   {16'd0, fetch_cnt}, 32'd0);

        // 1: straight-line fetch into HALT
        ack_en = 1'b1; dec_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1; #1;
        step();
        chk("t1_req0",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", {16'd0, imem_addr}, 32'h0000);
        step();
        chk("t1_valid0", {31'd0, dec_valid}, 32'd1);
        chk("t1_pc0",    {16'd0, dec_pc},     32'h0000);
        chk("t1_instr0", {16'd0, dec_instr},  32'h4000);
        chk("t1_inc0",   {16'd0, dec_pc_inc}, 32'h0002);
        step();
        chk("t1_addr1", {16'd0, imem_addr}, 32'h0002);
        chk("t1_cnt1",  {16'd0, fetch_cnt}, 32'd1);
        step();
        chk("t1_pc1", {16'd0, dec_pc}, 32'h0002);
        step();
        chk("t1_halt", {31'd0, halted},    32'd1);
        chk("t1_cnt2", {16'd0, fetch_cnt}, 32'd2);
        chk("t1_noreq", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step(2);
        redirect_valid = 1'b0;
        chk("t1_halt_redir", {31'd0, halted},   32'd1);
        chk("t1_halt_req",   {31'd0, imem_req}, 32'd0);

        // 2: decode stall in HOLD
        dec_ready = 1'b0;
        do_reset();
        step(2);
        chk("t2_hold", {31'd0, dec_valid}, 32'd1);
        step(5);
        chk("t2_instr", {16'd0, dec_instr}, 32'h4000);
        chk("t2_pc",    {16'd0, dec_pc},    32'h0000);
        chk("t2_req",   {31'd0, imem_req},  32'd0);
        chk("t2_cnt",   {16'd0, fetch_cnt}, 32'd0);

        // 3: redirect beats dec_ready in HOLD; bit 0 dropped
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0041;
        step();
        redirect_valid = 1'b0;
        chk("t3_cnt",  {16'd0, fetch_cnt}, 32'd0);
        chk("t3_addr", {16'd0, imem_addr}, 32'h0040);
        chk("t3_req",  {31'd0, imem_req},  32'd1);
        dec_ready = 1'b0;
        step();
        chk("t3_pc",    {16'd0, dec_pc},    32'h0040);
        chk("t3_instr", {16'd0, dec_instr}, 32'h0820);

        // 4: redirect in FETCH while ack is held off
        ack_en = 1'b0; dec_ready = 1'b1;
        step();
        chk("t4_cnt",  {16'd0, fetch_cnt}, 32'd1);
        chk("t4_addr", {16'd0, imem_addr}, 32'h0042);
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0080;
        step();
        redirect_valid = 1'b0;
        chk("t4_addr_hold0", {16'd0, imem_addr}, 32'h0042);
        step(2);
        chk("t4_addr_hold2", {16'd0, imem_addr}, 32'h0042);
        chk("t4_req_hold",   {31'd0, imem_req},  32'd1);
        ack_en = 1'b1;
        step();
        chk("t4_squash_valid", {31'd0, dec_valid}, 32'd0);
        chk("t4_addr_new",     {16'd0, imem_addr}, 32'h0080);
        step();
        chk("t4_pc",    {16'd0, dec_pc},    32'h0080);
        chk("t4_instr", {16'd0, dec_instr}, 32'h0840);

        // 5: PC wrap at the top of memory
        mem[32767] = 16'h4000;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        chk("t5_addr", {16'd0, imem_addr}, 32'hFFFE);
        step();
        chk("t5_pc",  {16'd0, dec_pc},     32'hFFFE);
        chk("t5_inc", {16'd0, dec_pc_inc}, 32'h0000);
        dec_ready = 1'b1;
        step();
        chk("t5_wrap_addr", {16'd0, imem_addr}, 32'h0000);
        chk("t5_cnt",       {16'd0, fetch_cnt}, 32'd2);

        // redirect in FETCH coincident with ack: word dropped, new address
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        chk("t5b_valid", {31'd0, dec_valid}, 32'd0);
        chk("t5b_addr",  {16'd0, imem_addr}, 32'h0010);
        step();
        chk("t5b_pc",    {16'd0, dec_pc},    32'h0010);
        chk("t5b_instr", {16'd0, dec_instr}, 32'h0808);

        // 6: asynchronous reset in HOLD, FETCH and HALT
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_hold_valid", {31'd0, dec_valid}, 32'd0);
        chk("t6_hold_instr", {16'd0, dec_instr}, 32'd0);
        chk("t6_hold_pc",    {16'd0, dec_pc},    32'd0);
        chk("t6_hold_cnt",   {16'd0, fetch_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        step();
        chk("t6_addr_after", {16'd0, imem_addr}, 32'h0000);
        chk("t6_req_after",  {31'd0, imem_req},  32'd1);
        ack_en = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_fetch_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        ack_en = 1'b1; dec_ready = 1'b1;
        step(5);
        chk("t6_pre_halt", {31'd0, halted}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_halt_clr", {31'd0, halted},    32'd0);
        chk("t6_halt_cnt", {16'd0, fetch_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        step();
        chk("t6_final_addr", {16'd0, imem_addr}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
